// File: rtl/lifo_memory.sv
// Synchronous LIFO stack: one push, pop or swap per clock, registered pop data,
// flags decoded straight from the entry count.
module lifo_memory #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int PTR_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              lifo_empty,
    output logic              lifo_full,
    output logic [PTR_W-1:0]  pointer1
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  ptr_reg;
    logic [PTR_W-1:0]  ptr_next;
    logic [PTR_W-1:0]  ptr_dec;
    logic [DATA_W-1:0] data_out_reg;
    logic [ADDR_W-1:0] free_addr;
    logic [ADDR_W-1:0] top_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              do_push;
    logic              do_pop;
    logic              do_swap;
    logic              do_write;
    logic              do_read;

    assign lifo_empty = (ptr_reg == '0);
    assign lifo_full  = (ptr_reg == PTR_W'(DEPTH));
    assign pointer1   = ptr_reg;
    assign data_out   = data_out_reg;

    assign ptr_dec   = ptr_reg - PTR_W'(1);
    assign free_addr = ptr_reg[ADDR_W-1:0];
    assign top_addr  = ptr_dec[ADDR_W-1:0];

    // wr+rd on an empty stack degrades to a plain push; on a non-empty
    // stack it replaces the top entry, which is legal even when full.
    always_comb begin
        do_push  = 1'b0;
        do_pop   = 1'b0;
        do_swap  = 1'b0;
        if (wr && rd) begin
            do_swap = !lifo_empty;
            do_push = lifo_empty;
        end else if (wr) begin
            do_push = !lifo_full;
        end else if (rd) begin
            do_pop = !lifo_empty;
        end
    end

    assign do_write = do_push || do_swap;
    assign do_read  = do_pop || do_swap;
    assign wr_addr  = do_swap ? top_addr : free_addr;

    always_comb begin
        ptr_next = ptr_reg;
        if (do_push) begin
            ptr_next = ptr_reg + PTR_W'(1);
        end else if (do_pop) begin
            ptr_next = ptr_dec;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ptr_reg      <= '0;
            data_out_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
            if (do_read) begin
                data_out_reg <= mem[top_addr];
            end
        end
    end

    // Storage carries no reset; the write is gated so an edge under reset
    // cannot land a half-completed push.
    always_ff @(posedge clk) begin
        if (do_write && !rst_n) begin
            mem[wr_addr] <= data_in;
        end
    end

endmodule

// File: tb/tb_lifo_memory.sv
// Directed bench for lifo_memory: reset, push/pop order, full/empty guards,
// swap behaviour and asynchronous reset, all against hand-computed values.
module tb_lifo_memory;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 512;
    localparam int PTR_W  = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              lifo_empty;
    logic              lifo_full;
    logic [PTR_W-1:0]  pointer1;

    int tests_run = 0;
    int tests_failed = 0;

    lifo_memory #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr         (wr),
        .rd         (rd),
        .data_in    (data_in),
        .data_out   (data_out),
        .lifo_empty (lifo_empty),
        .lifo_full  (lifo_full),
        .pointer1   (pointer1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one request and let one rising edge consume it; inputs are left
    // as set so back-to-back calls model a request held high.
    task automatic op(input logic w, input logic r, input logic [31:0] d);
        wr      = w;
        rd      = r;
        data_in = d;
        @(posedge clk);
        #1;
        $display("[TB] wr=%0b rd=%0b din=%h -> ptr=%0d dout=%h empty=%0b full=%0b",
                 w, r, d, pointer1, data_out, lifo_empty, lifo_full);
    endtask

    task automatic idle();
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        data_in = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        check("reset_ptr",   32'(pointer1), 32'd0);
        check("reset_dout",  data_out, 32'h0000_0000);
        check("reset_empty", 32'(lifo_empty), 32'd1);
        check("reset_full",  32'(lifo_full), 32'd0);

        // push two, then hold rd across three edges
        op(1'b1, 1'b0, 32'h8000_0000);
        op(1'b1, 1'b0, 32'h4000_0000);
        idle();
        check("push2_ptr",   32'(pointer1), 32'd2);
        check("push2_dout",  data_out, 32'h0000_0000);
        check("push2_empty", 32'(lifo_empty), 32'd0);
        op(1'b0, 1'b1, 32'h0);
        check("pop1_dout", data_out, 32'h4000_0000);
        check("pop1_ptr",  32'(pointer1), 32'd1);
        op(1'b0, 1'b1, 32'h0);
        check("pop2_dout",  data_out, 32'h8000_0000);
        check("pop2_ptr",   32'(pointer1), 32'd0);
        check("pop2_empty", 32'(lifo_empty), 32'd1);
        op(1'b0, 1'b1, 32'h0);
        idle();
        check("pop_empty_dout", data_out, 32'h8000_0000);
        check("pop_empty_ptr",  32'(pointer1), 32'd0);

        // fill to DEPTH
        for (int i = 0; i < DEPTH; i++) begin
            op(1'b1, 1'b0, 32'(i));
        end
        idle();
        check("fill_full", 32'(lifo_full), 32'd1);
        check("fill_ptr",  32'(pointer1), 32'd512);
        op(1'b1, 1'b0, 32'hDEAD_BEEF);
        idle();
        check("overflow_ptr",  32'(pointer1), 32'd512);
        check("overflow_dout", data_out, 32'h8000_0000);
        op(1'b0, 1'b1, 32'h0);
        idle();
        check("pop_after_full_dout", data_out, 32'd511);
        check("pop_after_full_ptr",  32'(pointer1), 32'd511);
        check("pop_after_full_flag", 32'(lifo_full), 32'd0);

        // swap while full
        op(1'b1, 1'b0, 32'h0000_0777);
        idle();
        check("refill_full", 32'(lifo_full), 32'd1);
        op(1'b1, 1'b1, 32'h0000_0999);
        idle();
        check("swap_full_dout", data_out, 32'h0000_0777);
        check("swap_full_ptr",  32'(pointer1), 32'd512);
        op(1'b0, 1'b1, 32'h0);
        idle();
        check("swap_full_pop", data_out, 32'h0000_0999);
        op(1'b0, 1'b1, 32'h0);
        idle();
        check("below_top_pop", data_out, 32'd510);

        // synchronous-point reset between sections, with wr held: push must abort
        rst_n = 1'b1;
        op(1'b1, 1'b0, 32'h0000_1111);
        check("rst_abort_ptr", 32'(pointer1), 32'd0);
        idle();
        rst_n = 1'b0;

        // swap with [0xA, 0xB]
        op(1'b1, 1'b0, 32'h0000_000A);
        op(1'b1, 1'b0, 32'h0000_000B);
        op(1'b1, 1'b1, 32'h0000_000C);
        idle();
        check("swap_dout", data_out, 32'h0000_000B);
        check("swap_ptr",  32'(pointer1), 32'd2);
        op(1'b0, 1'b1, 32'h0);
        check("swap_pop_dout", data_out, 32'h0000_000C);
        check("swap_pop_ptr",  32'(pointer1), 32'd1);
        op(1'b0, 1'b1, 32'h0);
        idle();
        check("swap_pop2_dout", data_out, 32'h0000_000A);

        // wr+rd on empty acts as push
        op(1'b1, 1'b1, 32'h0000_0005);
        idle();
        check("swap_empty_ptr",  32'(pointer1), 32'd1);
        check("swap_empty_dout", data_out, 32'h0000_000A);
        op(1'b0, 1'b1, 32'h0);
        idle();
        check("swap_empty_pop", data_out, 32'h0000_0005);
        check("swap_empty_ptr0", 32'(pointer1), 32'd0);

        // asynchronous reset between edges
        op(1'b1, 1'b0, 32'h0000_0001);
        op(1'b1, 1'b0, 32'h0000_0002);
        op(1'b1, 1'b0, 32'h0000_0003);
        idle();
        check("pre_async_ptr", 32'(pointer1), 32'd3);
        #3;
        rst_n = 1'b1;
        #1;
        check("async_ptr",   32'(pointer1), 32'd0);
        check("async_empty", 32'(lifo_empty), 32'd1);
        check("async_dout",  data_out, 32'h0000_0000);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        op(1'b0, 1'b1, 32'h0);
        idle();
        check("post_async_pop_ptr",  32'(pointer1), 32'd0);
        check("post_async_pop_dout", data_out, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lifo_memory.md
Name: lifo_memory

Overview:
- Synchronous last-in-first-out stack, 32-bit words, default depth 512 entries.
- Buffers data words between a producer and a consumer that need reverse-order retrieval.
- Provides empty/full status flags and exposes the current stack pointer (entry count) for debug and flow control.
- Single clock domain; storage is an inferred register/RAM array.

Parameters:
- DATA_W, 32, width of each stored word and of data_in/data_out.
- DEPTH, 512, number of storage entries; must satisfy DEPTH <= 2^PTR_W - 1.
- PTR_W, 10, width of pointer1 (entry counter).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-high (asserted = 1) despite the port name; it clears pointer1 and data_out.
- wr  input  1  push request, sampled at the rising edge of clk.
- rd  input  1  pop request, sampled at the rising edge of clk.
- data_in  input  DATA_W  word to push.
- data_out  output  DATA_W  registered popped word.
- lifo_empty  output  1  high when pointer1 == 0.
- lifo_full  output  1  high when pointer1 == DEPTH.
- pointer1  output  PTR_W  number of valid entries; next free slot index.

Behaviour:
- Reset, asynchronous while rst_n = 1:
  - pointer1 = 0 and data_out = 0.
  - lifo_empty = 1 and lifo_full = 0.
  - Memory contents are not cleared and are undefined after reset.
  - Reset asserted mid-operation aborts any push or pop in progress on that edge.
- Flags are combinational decodes of pointer1; they change in the same cycle as pointer1 and have no extra latency.
- Push (wr = 1, rd = 0, not full):
  - mem[pointer1] <= data_in.
  - pointer1 <= pointer1 + 1.
  - data_out holds its value.
- Pop (rd = 1, wr = 0, not empty):
  - data_out <= mem[pointer1 - 1], valid on the first rising edge after rd is sampled (1-cycle latency).
  - pointer1 <= pointer1 - 1.
- Push when full: ignored; memory, pointer1 and data_out are unchanged. There is no wrap-around.
- Pop when empty: ignored; pointer1 stays 0 and data_out holds its last value. No underflow wrap.
- Simultaneous wr = 1 and rd = 1:
  - If not empty, swap: data_out <= mem[pointer1 - 1] and mem[pointer1 - 1] <= data_in, with pointer1 unchanged. This is allowed when full.
  - If empty, treated as a push only (write data_in, pointer1 + 1, data_out unchanged).
- Idle (wr = 0, rd = 0): all state holds.
- Continuous wr or rd held high performs one operation per clock.
- pointer1 arithmetic is unsigned and saturates at the bounds only through the full/empty guards.

Test Plan:
- Reset: assert rst_n = 1 for one cycle -> pointer1 = 0, data_out = 0x00000000, lifo_empty = 1, lifo_full = 0.
- Push then pop: push 0x80000000, then push 0x40000000 -> pointer1 = 2. Then hold rd = 1:
  - 1st edge: data_out = 0x40000000, pointer1 = 1.
  - 2nd edge: data_out = 0x80000000, pointer1 = 0, lifo_empty = 1.
  - 3rd edge: all outputs unchanged (pop on empty ignored).
- Fill: push DEPTH words 0..511 -> lifo_full = 1 and pointer1 = 512. One more push of 0xDEADBEEF -> ignored. Pop -> data_out = 511 (not 0xDEADBEEF).
- Simultaneous: with stack holding [0xA, 0xB] (0xB on top), assert wr = 1, rd = 1, data_in = 0xC -> data_out = 0xB, pointer1 = 2. Next pop -> data_out = 0xC.
- Simultaneous on empty: wr = 1, rd = 1, data_in = 0x5 -> pointer1 = 1 and data_out unchanged. Next pop -> data_out = 0x5.
- Async reset mid-stream: after 3 pushes, raise rst_n between clock edges -> pointer1 = 0 and lifo_empty = 1 immediately, before the next edge.
